poly_voice_mixer: RTL and testbench
===================================

Name: poly_voice_mixer

Overview:
- Polyphonic successor to the single-oscillator audio path.
- Generates VOICES phase-accumulator voices, each with its own gate and an attack/sustain/release envelope.
- Voices are processed time-multiplexed, one per clk, after each sample tick, then summed with saturation.
- Output is offset-binary pcm that drives the existing dac block directly.

Parameters:
- VOICES, 4, number of voices (power of 2, 2..16)
- BITDEPTH, 14, pcm width
- BITFRACTION, 6, extra phase fraction bits; phase width PW = BITDEPTH+BITFRACTION
- INCWIDTH, 21, per-voice phase increment width
- ENVBITS, 8, envelope level width; max level EMAX = 2^ENVBITS-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_tick  in  1  one-clk strobe per audio sample
- gate  in  VOICES  per-voice note gate, bit i = voice i
- increment  in  VOICES*INCWIDTH  flat bus, voice i at [i*INCWIDTH +: INCWIDTH]
- attack_rate  in  ENVBITS  envelope step per sample in ATTACK; 0 = instant
- release_rate  in  ENVBITS  envelope step per sample in RELEASE; 0 = instant
- pcm  out  BITDEPTH  mixed sample, offset binary
- pcm_valid  out  1  one-clk pulse when pcm updates
- busy  out  1  sequencer running
- voice_active  out  VOICES  bit i high when voice i is not in IDLE

Behaviour:
- Reset (async, applied immediately):
  - pcm = 2^(BITDEPTH-1); pcm_valid = busy = 0; voice_active = 0.
  - All phases and envelope levels = 0; all voices in IDLE; sequencer in SEQ_IDLE.
- Sequencer FSM: SEQ_IDLE -> SEQ_VOICE -> SEQ_OUT -> SEQ_IDLE.
  - SEQ_IDLE: on sample_tick, clear accumulator, set slot=0, busy=1, go to SEQ_VOICE.
  - SEQ_VOICE: one voice per clk, slot 0..VOICES-1; after the last slot go to SEQ_OUT.
  - SEQ_OUT: load pcm, pulse pcm_valid, clear busy, return to SEQ_IDLE.
  - pcm_valid is asserted exactly VOICES+1 clks after the sample_tick cycle.
  - sample_tick while busy=1 is dropped; no queueing.
- Per-voice slot i (gate[i] and increment slice sampled in this cycle only):
  - Envelope update first, then phase update, then waveform.
  - IDLE: gate=1 -> ATTACK.
  - ATTACK:
    - env += attack_rate, saturating at EMAX.
    - Reaching EMAX -> SUSTAIN.
    - attack_rate=0 -> env=EMAX, SUSTAIN in the same slot.
  - SUSTAIN: env holds.
  - ATTACK or SUSTAIN with gate=0 -> RELEASE; the level is not changed in that slot.
  - RELEASE:
    - env -= release_rate, floor 0.
    - release_rate=0 -> env=0.
    - env reaching 0 -> IDLE and phase cleared to 0.
    - gate=1 in RELEASE -> ATTACK from the current env (no reset to 0).
  - Phase: phase += zero-extended increment, modulo 2^PW. Phase advances only when the voice is not IDLE after the envelope update.
  - Waveform (sawtooth): wave = phase[PW-1 -: BITDEPTH] - 2^(BITDEPTH-1), signed.
  - Contribution = (wave * env) >>> ENVBITS (arithmetic shift). Added to a signed accumulator of BITDEPTH+log2(VOICES) bits.
  - IDLE voices contribute 0.
- SEQ_OUT arithmetic:
  - Clamp the accumulator to [-2^(BITDEPTH-1), 2^(BITDEPTH-1)-1].
  - pcm = clamped + 2^(BITDEPTH-1).
- voice_active is updated in each voice's slot.
- Reset mid-sequence: everything returns to reset values; no pcm_valid is emitted.

Optional Feature:
- Macro: POLY_WAVE_SELECT_EN.
- Defined:
  - Adds input wave_sel, width VOICES*2, voice i at [2i +: 2], sampled in its slot.
  - 0 = saw.
  - 1 = square: +(2^(BITDEPTH-1)-1) when the phase MSB is 0, else -2^(BITDEPTH-1).
  - 2 = triangle: top BITDEPTH+1 phase bits folded, full-scale signed.
  - 3 = silence: contributes 0; the envelope still runs.
- Undefined: port absent; all voices saw.

Test Plan (VOICES=4, BITDEPTH=14, BITFRACTION=6, ENVBITS=8):
1. Reset, then sample_tick, gate=0 -> busy high for 5 clks; pcm_valid at tick+5; pcm=8192; voice_active=0.
2. gate=0001, attack_rate=0, increment0=262144, one tick -> voice_active=0001; wave=-4096, env=255, contribution -4080, pcm=4112.
3. gate=0001, attack_rate=64, 4 ticks -> env 64,128,192,255; SUSTAIN entered on tick 4.
4. From SUSTAIN, gate=0, release_rate=100 -> env 255,155,55,0 on ticks 1-4 (tick 1 only enters RELEASE). voice_active[0] falls on the 4th tick; phase=0.
5. gate=1111, attack_rate=0, all increments=1048512, one tick -> each contribution 8159, sum 32636 clamped -> pcm=16383. Same with increments=2^19 -> each contribution 0 -> pcm=8192.
6. sample_tick repeated at tick+2 -> ignored, single pcm_valid. rst asserted at tick+3 -> pcm=8192, busy=0, no pcm_valid, all envelopes 0.

Source files
------------

// File: rtl/poly_voice_mixer.sv
// Time-multiplexed polyphonic mixer: VOICES phase-accumulator voices with attack/sustain/release
// envelopes, summed with saturation into offset-binary pcm. Optional POLY_WAVE_SELECT_EN adds wave_sel.
module poly_voice_mixer #(
    parameter int VOICES      = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6,
    parameter int INCWIDTH    = 21,
    parameter int ENVBITS     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [VOICES-1:0]            gate,
    input  logic [VOICES*INCWIDTH-1:0]   increment,
    input  logic [ENVBITS-1:0]           attack_rate,
    input  logic [ENVBITS-1:0]           release_rate,
`ifdef POLY_WAVE_SELECT_EN
    input  logic [VOICES*2-1:0]          wave_sel,
`endif
    output logic [BITDEPTH-1:0]          pcm,
    output logic                         pcm_valid,
    output logic                         busy,
    output logic [VOICES-1:0]            voice_active
);

    localparam int PW = BITDEPTH + BITFRACTION;
    localparam int SW = $clog2(VOICES);
    localparam int AW = BITDEPTH + SW;
    localparam int XW = (PW > INCWIDTH) ? PW : INCWIDTH;

    localparam logic [ENVBITS-1:0]       EMAX     = '1;
    localparam logic [SW-1:0]            LAST     = SW'(VOICES - 1);
    localparam logic [BITDEPTH-1:0]      HALF     = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic signed [AW-1:0]     SAT_HI   = AW'((1 <<< (BITDEPTH-1)) - 1);
    localparam logic signed [AW-1:0]     SAT_LO   = ~SAT_HI;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_VOICE, SEQ_OUT} seq_t;
    typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} vst_t;

    function automatic logic [ENVBITS-1:0] env_up(input logic [ENVBITS-1:0] env,
                                                  input logic [ENVBITS-1:0] rate);
        logic [ENVBITS:0] s;
        s = {1'b0, env} + {1'b0, rate};
        if (rate == '0 || s[ENVBITS])
            return EMAX;
        return s[ENVBITS-1:0];
    endfunction

    function automatic logic [ENVBITS-1:0] env_dn(input logic [ENVBITS-1:0] env,
                                                  input logic [ENVBITS-1:0] rate);
        if (rate == '0 || env <= rate)
            return '0;
        return env - rate;
    endfunction

    // Clamp to the signed pcm range, then flip the MSB to add the offset-binary midpoint.
    function automatic logic [BITDEPTH-1:0] sat_to_pcm(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] c;
        if (a > SAT_HI)
            c = SAT_HI;
        else if (a < SAT_LO)
            c = SAT_LO;
        else
            c = a;
        return {~c[BITDEPTH-1], c[BITDEPTH-2:0]};
    endfunction

    seq_t                          seq_q, seq_d;
    logic [SW-1:0]                 slot_q, slot_d;
    logic signed [AW-1:0]          acc_q, acc_d;
    logic [BITDEPTH-1:0]           pcm_q, pcm_d;
    logic                          pcm_valid_q, pcm_valid_d;
    logic                          busy_q, busy_d;

    vst_t                          vst_q   [VOICES];
    logic [ENVBITS-1:0]            env_q   [VOICES];
    logic [PW-1:0]                 phase_q [VOICES];

    logic                          g_cur;
    logic [INCWIDTH-1:0]           inc_cur;
    vst_t                          vst_cur, vst_d;
    logic [ENVBITS-1:0]            env_cur, env_d;
    logic [PW-1:0]                 ph_cur, phase_d;
    logic [XW-1:0]                 ph_sum;
    logic signed [BITDEPTH-1:0]    wave;
    logic signed [BITDEPTH+ENVBITS:0] prod;
    logic signed [BITDEPTH-1:0]    contrib;
    logic signed [AW-1:0]          contrib_x;
`ifdef POLY_WAVE_SELECT_EN
    logic [1:0]                    ws_cur;
    logic [BITDEPTH:0]             tri_top;
    logic [BITDEPTH-1:0]           tri_fold;
`endif

    assign g_cur   = gate[slot_q];
    assign inc_cur = increment[slot_q*INCWIDTH +: INCWIDTH];
    assign vst_cur = vst_q[slot_q];
    assign env_cur = env_q[slot_q];
    assign ph_cur  = phase_q[slot_q];
`ifdef POLY_WAVE_SELECT_EN
    assign ws_cur  = wave_sel[slot_q*2 +: 2];
`endif

    // Envelope of the voice in the current slot; a gate-on from IDLE or RELEASE steps immediately.
    always_comb begin
        vst_d = vst_cur;
        env_d = env_cur;
        case (vst_cur)
            V_IDLE, V_RELEASE: begin
                if (g_cur) begin
                    env_d = env_up(env_cur, attack_rate);
                    vst_d = (env_d == EMAX) ? V_SUSTAIN : V_ATTACK;
                end else if (vst_cur == V_RELEASE) begin
                    env_d = env_dn(env_cur, release_rate);
                    if (env_d == '0)
                        vst_d = V_IDLE;
                end
            end
            V_ATTACK: begin
                if (!g_cur) begin
                    vst_d = V_RELEASE;
                end else begin
                    env_d = env_up(env_cur, attack_rate);
                    if (env_d == EMAX)
                        vst_d = V_SUSTAIN;
                end
            end
            V_SUSTAIN: begin
                if (!g_cur)
                    vst_d = V_RELEASE;
            end
            default: ;
        endcase
    end

    // Phase, waveform and scaled contribution for the current slot.
    always_comb begin
        ph_sum  = XW'(ph_cur) + XW'(inc_cur);
        phase_d = (vst_d == V_IDLE) ? '0 : PW'(ph_sum);
        wave    = $signed(phase_d[PW-1 -: BITDEPTH] - HALF);
`ifdef POLY_WAVE_SELECT_EN
        tri_top  = phase_d[PW-1 -: BITDEPTH+1];
        tri_fold = tri_top[BITDEPTH] ? ~tri_top[BITDEPTH-1:0] : tri_top[BITDEPTH-1:0];
        case (ws_cur)
            2'd1:    wave = phase_d[PW-1] ? $signed(HALF) : $signed(~HALF);
            2'd2:    wave = $signed(tri_fold - HALF);
            2'd3:    wave = '0;
            default: ;
        endcase
`endif
        prod    = wave * $signed({1'b0, env_d});
        contrib = BITDEPTH'(prod >>> ENVBITS);
        if (vst_d == V_IDLE)
            contrib = '0;
        contrib_x = {{SW{contrib[BITDEPTH-1]}}, contrib};
    end

    always_comb begin
        seq_d       = seq_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        pcm_d       = pcm_q;
        busy_d      = busy_q;
        pcm_valid_d = 1'b0;
        case (seq_q)
            SEQ_IDLE: begin
                if (sample_tick) begin
                    acc_d  = '0;
                    slot_d = '0;
                    busy_d = 1'b1;
                    seq_d  = SEQ_VOICE;
                end
            end
            SEQ_VOICE: begin
                acc_d  = acc_q + contrib_x;
                slot_d = slot_q + 1'b1;
                if (slot_q == LAST) begin
                    pcm_d       = sat_to_pcm(acc_d);
                    pcm_valid_d = 1'b1;
                    seq_d       = SEQ_OUT;
                end
            end
            SEQ_OUT: begin
                busy_d = 1'b0;
                seq_d  = SEQ_IDLE;
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q       <= SEQ_IDLE;
            slot_q      <= '0;
            acc_q       <= '0;
            pcm_q       <= HALF;
            pcm_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                vst_q[i]   <= V_IDLE;
                env_q[i]   <= '0;
                phase_q[i] <= '0;
            end
        end else if (seq_q == SEQ_VOICE) begin
            vst_q[slot_q]   <= vst_d;
            env_q[slot_q]   <= env_d;
            phase_q[slot_q] <= phase_d;
        end
    end

    always_comb begin
        for (int i = 0; i < VOICES; i++)
            voice_active[i] = (vst_q[i] != V_IDLE);
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed scoreboard bench for poly_voice_mixer (VOICES=4, BITDEPTH=14, ENVBITS=8).
module tb_poly_voice_mixer;

    localparam int VOICES   = 4;
    localparam int INCWIDTH = 21;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       sample_tick = 1'b0;
    logic [VOICES-1:0]          gate = '0;
    logic [VOICES*INCWIDTH-1:0] increment = '0;
    logic [7:0]                 attack_rate = '0;
    logic [7:0]                 release_rate = '0;
`ifdef POLY_WAVE_SELECT_EN
    logic [VOICES*2-1:0]        wave_sel = '0;
`endif
    logic [13:0]                pcm;
    logic                       pcm_valid;
    logic                       busy;
    logic [VOICES-1:0]          voice_active;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    poly_voice_mixer #(.VOICES(4), .BITDEPTH(14), .BITFRACTION(6), .INCWIDTH(21), .ENVBITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .gate         (gate),
        .increment    (increment),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
`ifdef POLY_WAVE_SELECT_EN
        .wave_sel     (wave_sel),
`endif
        .pcm          (pcm),
        .pcm_valid    (pcm_valid),
        .busy         (busy),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Signed saw contribution for a 20-bit phase and 8-bit envelope, floor of the product / 256.
    function automatic int contrib(input int ph, input int env);
        int w;
        w = (ph >> 6) - 8192;
        return (w * env) >>> 8;
    endfunction

    function automatic int pcm_of(input int s);
        int c;
        c = s;
        if (c > 8191)
            c = 8191;
        if (c < -8192)
            c = -8192;
        return c + 8192;
    endfunction

    task automatic set_inc_all(input int v);
        for (int i = 0; i < VOICES; i++)
            increment[i*INCWIDTH +: INCWIDTH] = INCWIDTH'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat, output int bcnt);
        lat  = 1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (pcm_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1)
                bcnt++;
        end
        check({tag, "_valid"}, {31'd0, pcm_valid}, 1);
        check({tag, "_pcm"}, {18'd0, pcm}, exp_q.pop_front());
    endtask

    task automatic tick(input string tag, input int exp_pcm, input logic [VOICES-1:0] exp_act);
        int lat, bcnt;
        exp_q.push_back(exp_pcm);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_valid(tag, lat, bcnt);
        check({tag, "_lat"}, lat, 5);
        check({tag, "_busy"}, bcnt, 5);
        check({tag, "_act"}, {28'd0, voice_active}, {28'd0, exp_act});
        @(negedge clk);
        check({tag, "_end"}, {30'd0, busy, pcm_valid}, 0);
    endtask

    initial begin
        int env_seq [8];
        int lat, bcnt, nv, ph, ex;
        env_seq = '{64, 128, 192, 255, 255, 155, 55, 0};

        repeat (3) @(negedge clk);
        check("rst_pcm", {18'd0, pcm}, 8192);
        check("rst_valid", {31'd0, pcm_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_act", {28'd0, voice_active}, 0);
        rst = 1'b0;

        tick("silent", 8192, 4'b0000);

        gate = 4'b0001;
        attack_rate = 8'd0;
        increment[0 +: INCWIDTH] = 21'd262144;
        tick("one_voice", 4112, 4'b0001);

        do_reset();
        attack_rate  = 8'd64;
        release_rate = 8'd100;
        increment[0 +: INCWIDTH] = 21'd100000;
        for (int k = 1; k <= 8; k++) begin
            gate = (k <= 4) ? 4'b0001 : 4'b0000;
            ph   = (k == 8) ? 0 : k * 100000;
            ex   = (k == 8) ? 8192 : pcm_of(contrib(ph, env_seq[k-1]));
            tick($sformatf("env_k%0d", k), ex, (k < 8) ? 4'b0001 : 4'b0000);
        end
        gate = 4'b0001;
        attack_rate = 8'd0;
        tick("retrig_phase0", pcm_of(contrib(100000, 255)), 4'b0001);

        do_reset();
        gate = 4'b1111;
        attack_rate = 8'd0;
        set_inc_all(1048512);
        tick("clip_hi", 16383, 4'b1111);

        do_reset();
        set_inc_all(524288);
        tick("mid_zero", 8192, 4'b1111);

        do_reset();
        set_inc_all(262144);
        tick("clip_lo", 0, 4'b1111);

        do_reset();
        gate = 4'b0011;
        set_inc_all(786432);
        tick("sum_two", 16352, 4'b0011);

        do_reset();
        gate = 4'b0001;
        set_inc_all(262144);
        exp_q.push_back(4112);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_valid("drop_tick", lat, bcnt);
        check("drop_tick_lat", lat + 2, 5);
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (pcm_valid === 1'b1)
                nv++;
        end
        check("drop_tick_extra", nv, 0);

        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pcm", {18'd0, pcm}, 8192);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_valid", {31'd0, pcm_valid}, 0);
        check("midrst_act", {28'd0, voice_active}, 0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (pcm_valid === 1'b1)
                nv++;
        end
        check("midrst_novalid", nv, 0);

        attack_rate = 8'd64;
        tick("midrst_env0", 7168, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
